// File: rtl/cdr_pd_loop_core_if.sv
// Signal bundle between the CDR core and its user: serial input, recovered
// data, bang-bang votes and the 11-bit phase code for the interpolator.
`timescale 1ps/1ps
interface cdr_pd_loop_core_if;
   logic        din;
   logic        a;
   logic        up;
   logic        dn;
   logic [10:0] code;

   // Environment side: drives the serial stream, observes the loop.
   modport master (output din, input a, up, dn, code);
   // Core side.
   modport slave (input din, output a, up, dn, code);
endinterface

// File: rtl/cdr_pd_loop_core.sv
// Alexander bang-bang phase detector followed by a proportional-integral
// loop filter. The filter produces an 11-bit phase code, which wraps modulo
// 2048 and steers the external phase interpolator that generates clk.
// There is no handshake: every port is sampled or updated on every clock.
`timescale 1ps/1ps
module cdr_pd_loop_core #(
   parameter int KP    = 4,
   parameter int KI    = 1,
   parameter int FRAC  = 8,
   parameter int INT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cdr_pd_loop_core_if.slave     bus
);

   localparam int P_W = 11 + FRAC;

   // Integral bounds and step, one bit wider than the register so that the
   // sum can be tested against the limits before it is committed.
   localparam logic signed [INT_W:0] I_MAX_W = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic signed [INT_W:0] I_MIN_W = -I_MAX_W;
   localparam logic signed [INT_W:0] KI_W    = (INT_W+1)'(KI);
   // Proportional step, aligned to the code LSB inside the phase accumulator.
   localparam logic [P_W-1:0]        KP_P    = P_W'(KP) << FRAC;

   logic                    e_s;
   logic                    e;
   logic                    a_prev;
   logic                    a_q;
   logic                    up_q;
   logic                    dn_q;
   logic signed [INT_W-1:0] i_reg;
   logic [P_W-1:0]          p_reg;

   logic signed [INT_W:0]   i_sum;
   logic signed [INT_W-1:0] i_next;
   logic [P_W-1:0]          p_step;
   logic [P_W-1:0]          p_next;

   // Edge sample: taken half a period after the data sample, between bits.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) e_s <= 1'b0;
      else        e_s <= bus.din;
   end

   // Data sample, history and phase-detector votes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= 1'b0;
         a_prev <= 1'b0;
         e      <= 1'b0;
         up_q   <= 1'b0;
         dn_q   <= 1'b0;
      end else begin
         a_q    <= bus.din;
         a_prev <= a_q;
         e      <= e_s;
         up_q   <= a_prev ^ e;
         dn_q   <= e ^ a_q;
      end
   end

   // Loop filter arithmetic: vote to error, saturating integral, phase step.
   // A both-high vote cannot come from the detector; it is treated as no vote.
   always_comb begin
      i_sum  = {i_reg[INT_W-1], i_reg};
      p_step = '0;
      if (up_q && !dn_q) begin
         i_sum  = {i_reg[INT_W-1], i_reg} + KI_W;
         p_step = KP_P;
      end else if (dn_q && !up_q) begin
         i_sum  = {i_reg[INT_W-1], i_reg} - KI_W;
         p_step = -KP_P;
      end
      if (i_sum > I_MAX_W)      i_next = I_MAX_W[INT_W-1:0];
      else if (i_sum < I_MIN_W) i_next = I_MIN_W[INT_W-1:0];
      else                      i_next = i_sum[INT_W-1:0];
      // The integral is added every cycle, so a frequency offset keeps
      // slewing the phase even while the detector is silent.
      p_next = p_reg + p_step + P_W'(i_next);
   end

   // Filter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_reg <= '0;
         p_reg <= '0;
      end else begin
         i_reg <= i_next;
         p_reg <= p_next;
      end
   end

   assign bus.a    = a_q;
   assign bus.up   = up_q;
   assign bus.dn   = dn_q;
   assign bus.code = p_reg[P_W-1:FRAC];

endmodule

// File: tb/tb_cdr_pd_loop_core.sv
// Directed bench for cdr_pd_loop_core: reset behaviour, constant data,
// late and early clock patterns, code wrap, and integral saturation on a
// second instance built with a 6-bit integrator.
`timescale 1ps/1ps
module tb_cdr_pd_loop_core;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   up_cnt;
   int   dn_cnt;

   cdr_pd_loop_core_if if_main ();
   cdr_pd_loop_core_if if_sat ();

   assign if_sat.din = if_main.din;

   cdr_pd_loop_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_main)
   );

   cdr_pd_loop_core #(.INT_W(6)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_sat)
   );

   // 200 ps clock, first rising edge at 100 ps.
   always #100 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Leaves the bench 50 ps after a rising edge with reset just released.
   task automatic do_reset();
      rst_n       = 1'b0;
      if_main.din = 1'b0;
      repeat (2) @(posedge clk);
      #50 rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held while the input toggles.
      rst_n       = 1'b0;
      if_main.din = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #30 if_main.din = ~if_main.din;
      end
      #20;
      check("rst_a",        32'(if_main.a),    0);
      check("rst_up",       32'(if_main.up),   0);
      check("rst_dn",       32'(if_main.dn),   0);
      check("rst_code",     32'(if_main.code), 0);
      check("rst_code_sat", 32'(if_sat.code),  0);

      // Constant ones: a single Up from the 0->1 step, then silence.
      do_reset();
      if_main.din = 1'b1;
      up_cnt = 0;
      dn_cnt = 0;
      for (int n = 1; n <= 50; n++) begin
         @(posedge clk);
         #50;
         up_cnt += int'(if_main.up);
         dn_cnt += int'(if_main.dn);
         if (n == 3) check("const_code_n3", 32'(if_main.code), 4);
      end
      check("const_up_cnt", 32'(up_cnt), 1);
      check("const_dn_cnt", 32'(dn_cnt), 0);
      check("const_code",   32'(if_main.code), 4);
      check("const_a",      32'(if_main.a), 1);

      // Late clock: data changes 20 ps after each rising edge. The first
      // vote lands at edge 3, so edge n carries the effect of m = n-3 votes:
      // P = 1024*m + m*(m+1)/2 while the integral is unsaturated.
      do_reset();
      for (int n = 1; n <= 428; n++) begin
         @(posedge clk);
         #20 if_main.din = n[0];
         #30;
         if (n >= 2 && n <= 8) check($sformatf("late_a_%0d", n), 32'(if_main.a), 32'((n - 1) & 1));
         if (n >= 3 && n <= 8) begin
            check($sformatf("late_up_%0d", n), 32'(if_main.up), 1);
            check($sformatf("late_dn_%0d", n), 32'(if_main.dn), 0);
         end
         case (n)
            3:   check("late_code_n3",   32'(if_main.code), 0);
            4:   check("late_code_n4",   32'(if_main.code), 4);
            5:   check("late_code_n5",   32'(if_main.code), 8);
            6:   check("late_code_n6",   32'(if_main.code), 12);
            7:   check("late_code_n7",   32'(if_main.code), 16);
            34:  check("sat_code_m31",   32'(if_sat.code),  125);
            35:  check("sat_code_m32",   32'(if_sat.code),  130);
            103: check("sat_code_m100",  32'(if_sat.code),  410);
            104: check("sat_code_m101",  32'(if_sat.code),  414);
            426: check("wrap_code_m423", 32'(if_main.code), 2042);
            427: begin
               check("wrap_code_m424", 32'(if_main.code), 2047);
               check("wrap_up_m424",   32'(if_main.up),   1);
            end
            428: begin
               check("wrap_code_m425", 32'(if_main.code), 5);
               check("wrap_up_m425",   32'(if_main.up),   1);
            end
            default: ;
         endcase
      end

      // Reset mid-run, away from any clock edge: outputs clear at once.
      #20 rst_n = 1'b0;
      #1;
      check("mid_rst_a",        32'(if_main.a),    0);
      check("mid_rst_up",       32'(if_main.up),   0);
      check("mid_rst_code",     32'(if_main.code), 0);
      check("mid_rst_code_sat", 32'(if_sat.code),  0);

      // Early clock: data changes 20 ps before each rising edge. The first
      // Dn lands at edge 3; P = -(1025), -(2051), -(3078) wraps below zero.
      do_reset();
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         #50;
         if (n >= 2) check($sformatf("early_a_%0d", n), 32'(if_main.a), 32'((n - 1) & 1));
         if (n >= 3) begin
            check($sformatf("early_dn_%0d", n), 32'(if_main.dn), 1);
            check($sformatf("early_up_%0d", n), 32'(if_main.up), 0);
         end
         case (n)
            3: check("early_code_n3", 32'(if_main.code), 0);
            4: check("early_code_n4", 32'(if_main.code), 2043);
            5: check("early_code_n5", 32'(if_main.code), 2039);
            6: check("early_code_n6", 32'(if_main.code), 2035);
            default: ;
         endcase
         #130 if_main.din = n[0];
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
